// File: rtl/bus_driver_rr.sv
// bus_driver_rr: round-robin owned, registered tristate bus driver.
// Sources request a shared WIDTH-bit bus; one owner at a time drives
// registered data, and the bus floats whenever nobody owns it.
// Build option BUS_TURNAROUND_EN: when defined, every ownership release
// passes through a one-cycle TURN state so the bus is Z between owners.
// When undefined, a release hands straight over to the next requester.
module bus_driver_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       grant,
  output logic                      busy,
  output logic [WIDTH-1:0]          data_out
);
  localparam int IW = $clog2(CHANNELS);
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [IW-1:0]       base;
  logic [IW-1:0]       winner;
  logic                found;
  logic                others;
  logic                release_own;

  // Round-robin search starting just after base. While driving, the owner
  // is the base so a same-edge handoff skips it; otherwise last is the base.
  always_comb begin
    base   = (state_q == DRIVE) ? owner_q : last_q;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(base) + k) % CHANNELS);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Release decision for the current owner (voluntary drop or hold limit).
  always_comb begin
    others      = |(req & ~(CHANNELS'(1) << owner_q));
    release_own = !req[owner_q] || ((cnt_q == CNT_TOP) && others);
  end

  // State and datapath register; reset floats the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      last_q  <= IW'(CHANNELS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration, ownership, hold counter, data capture.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (found) begin
          state_d = DRIVE;
          owner_d = winner;
          grant_d = CHANNELS'(1) << winner;
          data_d  = data_in[int'(winner)*WIDTH +: WIDTH];
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        data_d = data_in[int'(owner_q)*WIDTH +: WIDTH];
        if (release_own) begin
          last_d = owner_q;
`ifdef BUS_TURNAROUND_EN
          state_d = TURN;
          grant_d = '0;
          busy_d  = 1'b0;
`else
          if (others) begin
            owner_d = winner;
            grant_d = CHANNELS'(1) << winner;
            data_d  = data_in[int'(winner)*WIDTH +: WIDTH];
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
`endif
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Outputs: registered grant/busy; bus driven only while busy.
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign data_out = busy_q ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_driver_rr.sv
// Directed bench for bus_driver_rr (WIDTH=8, CHANNELS=4, HOLD_MAX=4).
// Expectations follow BUS_TURNAROUND_EN so the same file covers both builds.
module tb_bus_driver_rr;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        busy;
  wire  [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  bus_driver_rr #(.WIDTH(8), .CHANNELS(4), .HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .grant(grant), .busy(busy), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int ch, input logic [7:0] v);
    data_in[ch*8 +: 8] = v;
  endtask

  task automatic own(input string tag, input logic [3:0] g, input logic [7:0] d);
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
  endtask

  task automatic floating(input string tag);
    chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_data"}, {24'd0, data_out}, {24'd0, 8'hzz});
  endtask

  // Release with another request pending: Z gap only with turnaround.
  task automatic handoff(input string tag, input logic [3:0] g, input logic [7:0] d);
`ifdef BUS_TURNAROUND_EN
    step();
    floating({tag, "_gap"});
`endif
    step();
    own(tag, g, d);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    data_in = '0;
    #2;
    floating("rst");

    @(negedge clk);
    rst_n = 1'b1;

    // sole requester ch0, one-cycle data latency
    req = 4'b0001;
    setd(0, 8'h55);
    step();
    own("t2a", 4'b0001, 8'h55);
    setd(0, 8'hAA);
    step();
    own("t2b", 4'b0001, 8'hAA);

    // async reset mid-drive floats the bus without an edge
    #2 rst_n = 1'b0;
    #1 floating("rst_mid");
    rst_n = 1'b1;

    // ch0 and ch2 contend: ch0 first after reset, forced out after 4 cycles
    req = 4'b0101;
    setd(0, 8'h11);
    setd(2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      own($sformatf("t3_hold%0d", i), 4'b0001, 8'h11);
    end
    handoff("t3_ch2", 4'b0100, 8'h22);

    // ch2 drops, ch1 takes over; then ch1 drops and bus goes idle
    req = 4'b0010;
    setd(1, 8'h33);
    handoff("t4_ch1", 4'b0010, 8'h33);
    req = 4'b0000;
    step();
    floating("t4_idle");
    step();
    floating("t4_idle2");

    // wrap: ch3 owns, ch0 pending, ch3 drops -> ch0 next
    req = 4'b1000;
    setd(3, 8'h44);
    step();
    own("t5_ch3", 4'b1000, 8'h44);
    req = 4'b1001;
    setd(0, 8'h66);
    step();
    own("t5_keep", 4'b1000, 8'h44);
    req = 4'b0001;
    handoff("t5_wrap", 4'b0001, 8'h66);

    // sole requester ch2 keeps the bus past HOLD_MAX
    req = 4'b0100;
    setd(2, 8'h77);
    handoff("t6_ch2", 4'b0100, 8'h77);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t6_hold%0d", i), {28'd0, grant}, 32'h4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
